// File: rtl/div_by_const_serial.sv
// Serial divisibility detector: streams a word MSB-nibble-first through a mod-DIVISOR residue accumulator.
// Define DIV_REM_OUT_EN to add the registered `remainder` output port.
module div_by_const_serial #(
    parameter int BIT_WIDTH = 32,
    parameter int DIVISOR   = 5
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [BIT_WIDTH-1:0] in,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic                 divisible
`ifdef DIV_REM_OUT_EN
    ,
    output logic [3:0]           remainder
`endif
);

    localparam int NIBBLES = (BIT_WIDTH + 3) / 4;
    localparam int SW      = NIBBLES * 4;
    localparam int CW      = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t          state, state_next;
    logic [SW-1:0]   shreg;
    logic [CW-1:0]   cnt;
    logic [3:0]      residue, residue_next;
    logic [7:0]      acc;
    logic            last;
    logic            divisible_q;
`ifdef DIV_REM_OUT_EN
    logic [3:0]      remainder_q;
`endif

    // residue < DIVISOR <= 15, so residue*16 + nibble never exceeds 8 bits
    always_comb begin
        acc          = {residue, shreg[SW-1 -: 4]};
        residue_next = 4'(acc % 8'(DIVISOR));
    end

    assign last = (cnt == CW'(NIBBLES - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_next;
    end

    always_comb begin
        state_next = state;
        in_ready   = 1'b0;
        out_valid  = 1'b0;
        case (state)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) state_next = RUN;
            end
            RUN: begin
                if (last) state_next = DONE;
            end
            DONE: begin
                out_valid = 1'b1;
                if (out_ready) state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            shreg       <= '0;
            cnt         <= '0;
            residue     <= '0;
            divisible_q <= 1'b0;
`ifdef DIV_REM_OUT_EN
            remainder_q <= '0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        shreg   <= SW'(in);
                        cnt     <= '0;
                        residue <= '0;
                    end
                end
                RUN: begin
                    shreg   <= shreg << 4;
                    cnt     <= cnt + CW'(1);
                    residue <= residue_next;
                    if (last) begin
                        divisible_q <= (residue_next == 4'd0);
`ifdef DIV_REM_OUT_EN
                        remainder_q <= residue_next;
`endif
                    end
                end
                default: ;
            endcase
        end
    end

    assign divisible = divisible_q;
`ifdef DIV_REM_OUT_EN
    assign remainder = remainder_q;
`endif

endmodule
